// File: rtl/alu_wide_sequencer.sv
// Runs 64-bit ADD/ADC/SUB/AND through an external 32-bit ALU, low word then high word.
// Optional completed-operation counter port op_count is enabled by defining ALU_SEQ_OP_COUNT_EN.
module alu_wide_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [63:0]       req_a,
    input  logic [63:0]       req_b,
    input  logic              req_cin,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_result,
    output logic [3:0]        resp_flags,
    output logic [3:0]        alu_op,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic              alu_cin,
    input  logic [31:0]       alu_out
`ifdef ALU_SEQ_OP_COUNT_EN
    ,
    output logic [CNT_W-1:0]  op_count
`endif
);

    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_e;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_ADC  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_AND  = 2'b11;
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd4;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    logic        cin_q, cin_d;
    logic        carry_q, carry_d;
    logic [63:0] result_q, result_d;
    logic [3:0]  flags_q, flags_d;

    logic        is_arith;
    logic [63:0] b_eff;
    logic        half_c;

    assign is_arith = (op_q != OP_AND);
    assign b_eff    = (op_q == OP_SUB) ? ~b_q : b_q;
    // Carry out of the current half, rebuilt from operand and sum MSBs.
    assign half_c   = (alu_a[31] & alu_b[31]) | ((alu_a[31] | alu_b[31]) & ~alu_out[31]);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        carry_d    = carry_q;
        result_d   = result_q;
        flags_d    = flags_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        alu_op     = 4'd0;
        alu_a      = 32'd0;
        alu_b      = 32'd0;
        alu_cin    = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
                    cin_d   = req_cin;
                    state_d = LO;
                end
            end
            LO: begin
                alu_op = is_arith ? ALU_ADD : ALU_AND;
                alu_a  = a_q[31:0];
                alu_b  = b_eff[31:0];
                case (op_q)
                    OP_ADC:  alu_cin = cin_q;
                    OP_SUB:  alu_cin = 1'b1;
                    default: alu_cin = 1'b0;
                endcase
                result_d[31:0] = alu_out;
                carry_d        = half_c;
                state_d        = HI;
            end
            HI: begin
                alu_op  = is_arith ? ALU_ADD : ALU_AND;
                alu_a   = a_q[63:32];
                alu_b   = b_eff[63:32];
                alu_cin = is_arith & carry_q;
                result_d[63:32] = alu_out;
                flags_d = {({alu_out, result_q[31:0]} == 64'd0),
                           alu_out[31],
                           is_arith & half_c,
                           is_arith & (a_q[63] == b_eff[63]) & (alu_out[31] != a_q[63])};
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            a_q      <= 64'd0;
            b_q      <= 64'd0;
            cin_q    <= 1'b0;
            carry_q  <= 1'b0;
            result_q <= 64'd0;
            flags_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign resp_result = result_q;
    assign resp_flags  = flags_q;

`ifdef ALU_SEQ_OP_COUNT_EN
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      count_q <= '0;
        else if (resp_valid && resp_ready) count_q <= count_q + 1'b1;
    end

    assign op_count = count_q;
`endif

endmodule
